// File: rtl/plug_pkg.sv
// Shared types for the plugboard bank: letter code, pair state, alphabet size.
// No logic, no latency, no flow control.
package plug_pkg;

   localparam int ALPHA_LEN = 26;

   typedef logic [4:0] letter_t;

   typedef enum logic [1:0] {
      EMPTY,
      HALF,
      FULL
   } pair_state_e;

endpackage

// File: rtl/plug_bank_if.sv
// Strobe/letter bus between a plugboard controller and plug_bank.
// The master drives the strobes and swap input; the slave returns pair status and the swap result.
interface plug_bank_if
   import plug_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int SEL_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
);

   logic [SEL_W-1:0]       SEL;
   logic                   LD;
   letter_t                LET;
   logic                   CLR;
   logic                   CLR_ALL;
   letter_t                SWAP_IN;
   logic [NUM_PAIRS-1:0]   ACT;
   logic [10*NUM_PAIRS-1:0] F;
   letter_t                SWAP_OUT;
   logic                   ERR;

   modport master (
      output SEL, LD, LET, CLR, CLR_ALL, SWAP_IN,
      input  ACT, F, SWAP_OUT, ERR
   );

   modport slave (
      input  SEL, LD, LET, CLR, CLR_ALL, SWAP_IN,
      output ACT, F, SWAP_OUT, ERR
   );

endinterface

// File: rtl/plug_pair_fsm.sv
// One plugboard pair: EMPTY/HALF/FULL state plus letter registers A and B.
// Updates one cycle after an ld/clr strobe; clr beats ld, no backpressure.
module plug_pair_fsm
   import plug_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    ld,
   input  logic    clr,
   input  letter_t ld_let,
   output letter_t a,
   output letter_t b,
   output logic    a_held,
   output logic    b_held
);

   pair_state_e state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         a     <= '0;
         b     <= '0;
      end else if (clr) begin
         state <= EMPTY;
         a     <= '0;
         b     <= '0;
      end else if (ld) begin
         case (state)
            EMPTY: begin
               a     <= ld_let;
               state <= HALF;
            end
            HALF: begin
               b     <= ld_let;
               state <= FULL;
            end
            FULL: begin
               // Reloading a full pair restarts it with the new letter as A.
               a     <= ld_let;
               b     <= '0;
               state <= HALF;
            end
            default: begin
               state <= EMPTY;
               a     <= '0;
               b     <= '0;
            end
         endcase
      end
   end

   assign a_held = (state != EMPTY);
   assign b_held = (state == FULL);

endmodule

// File: rtl/plug_bank.sv
// Bank of plugboard pairs with load/clear strobes, duplicate-letter rejection and letter swap.
// Pair status visible next cycle, SWAP_OUT/ERR registered with 1-cycle latency; no backpressure.
module plug_bank
   import plug_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int SEL_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
   input logic        CLK,
   input logic        RST,
   plug_bank_if.slave bus
);

   localparam logic [SEL_W:0] NP = (SEL_W + 1)'(NUM_PAIRS);

   letter_t                 pa [NUM_PAIRS];
   letter_t                 pb [NUM_PAIRS];
   letter_t                 sw_val [NUM_PAIRS];
   logic [NUM_PAIRS-1:0]    sel_oh;
   logic [NUM_PAIRS-1:0]    a_held;
   logic [NUM_PAIRS-1:0]    full;
   logic [NUM_PAIRS-1:0]    held_hit;
   logic [NUM_PAIRS-1:0]    sw_hit;
   logic [10*NUM_PAIRS-1:0] f_v;
   logic                    sel_bad;
   logic                    let_bad;
   logic                    ld_live;
   logic                    ld_ok;
   logic                    ld_rej;
   letter_t                 swap_or;
   letter_t                 swap_out_q;
   logic                    err_q;

   assign sel_bad = ({1'b0, bus.SEL} >= NP);
   assign let_bad = (bus.LET >= letter_t'(ALPHA_LEN));
   assign ld_live = bus.LD && !bus.CLR_ALL && !bus.CLR;
   assign ld_rej  = ld_live && (sel_bad || let_bad || (|held_hit));
   assign ld_ok   = ld_live && !(sel_bad || let_bad || (|held_hit));

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
      assign sel_oh[i] = (bus.SEL == SEL_W'(i));

      plug_pair_fsm u_pair (
         .clk    (CLK),
         .rst    (RST),
         .ld     (ld_ok && sel_oh[i]),
         .clr    (bus.CLR_ALL || (bus.CLR && sel_oh[i])),
         .ld_let (bus.LET),
         .a      (pa[i]),
         .b      (pb[i]),
         .a_held (a_held[i]),
         .b_held (full[i])
      );

      // A full target pair's own letters are about to be discarded, so they cannot conflict.
      assign held_hit[i] = !(sel_oh[i] && full[i]) &&
                           ((a_held[i] && (pa[i] == bus.LET)) ||
                            (full[i]   && (pb[i] == bus.LET)));

      assign sw_hit[i] = full[i] && ((bus.SWAP_IN == pa[i]) || (bus.SWAP_IN == pb[i]));
      assign sw_val[i] = !full[i]                ? '0    :
                         (bus.SWAP_IN == pa[i]) ? pb[i] :
                         (bus.SWAP_IN == pb[i]) ? pa[i] : '0;

      assign f_v[10*i +: 10] = {pb[i], pa[i]};
   end

   // Letters are unique across the bank, so at most one pair contributes to the OR.
   always_comb begin
      swap_or = '0;
      for (int k = 0; k < NUM_PAIRS; k++) begin
         swap_or = swap_or | sw_val[k];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         swap_out_q <= '0;
         err_q      <= 1'b0;
      end else begin
         swap_out_q <= (|sw_hit) ? swap_or : bus.SWAP_IN;
         err_q      <= ld_rej;
      end
   end

   assign bus.ACT      = full;
   assign bus.F        = f_v;
   assign bus.SWAP_OUT = swap_out_q;
   assign bus.ERR      = err_q;

endmodule

// File: tb/tb_plug_bank.sv
// Directed vector table plus hand sequences for held LD and asynchronous reset.
module tb_plug_bank;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   plug_bank_if #(.NUM_PAIRS(10), .SEL_W(4)) bus ();

   plug_bank #(.NUM_PAIRS(10), .SEL_W(4)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  sel;
      logic        ld;
      logic        clr;
      logic        clr_all;
      logic [4:0]  let_v;
      logic [4:0]  swap_in;
      logic [9:0]  act;
      logic [99:0] f;
      logic [4:0]  swap_out;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [99:0] pf(int idx, int b, int a);
      logic [99:0] r;
      r = '0;
      r[10*idx +: 10] = {5'(b), 5'(a)};
      return r;
   endfunction

   function automatic vec_t mk(int sel, bit ld, bit clr, bit clr_all, int let_v, int swap_in,
                               int act, logic [99:0] f, int swap_out, bit err);
      vec_t v;
      v.sel      = 4'(sel);
      v.ld       = ld;
      v.clr      = clr;
      v.clr_all  = clr_all;
      v.let_v    = 5'(let_v);
      v.swap_in  = 5'(swap_in);
      v.act      = 10'(act);
      v.f        = f;
      v.swap_out = 5'(swap_out);
      v.err      = err;
      return v;
   endfunction

   task automatic chk(string name, logic [99:0] got, logic [99:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic chk_all(string name, logic [9:0] act, logic [99:0] f, logic [4:0] sw, logic err);
      chk({name, ".act"},  100'(bus.ACT),      100'(act));
      chk({name, ".f"},    bus.F,              f);
      chk({name, ".swap"}, 100'(bus.SWAP_OUT), 100'(sw));
      chk({name, ".err"},  100'(bus.ERR),      100'(err));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int sel, bit ld, bit clr, bit clr_all, int let_v, int swap_in);
      bus.SEL     = 4'(sel);
      bus.LD      = ld;
      bus.CLR     = clr;
      bus.CLR_ALL = clr_all;
      bus.LET     = 5'(let_v);
      bus.SWAP_IN = 5'(swap_in);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(0, 0, 0, 0, 0, 0);

      //        sel ld clr all let sw  act     f                              swo err
      vecs.push_back(mk(0,  1, 0, 0,  0,  0, 0,      '0,                             0, 0));
      vecs.push_back(mk(0,  1, 0, 0, 25,  0, 1,      pf(0,25,0),                     0, 0));
      vecs.push_back(mk(0,  0, 0, 0,  0,  0, 1,      pf(0,25,0),                    25, 0));
      vecs.push_back(mk(0,  0, 0, 0,  0,  3, 1,      pf(0,25,0),                     3, 0));
      vecs.push_back(mk(0,  0, 0, 0,  0, 25, 1,      pf(0,25,0),                     0, 0));
      vecs.push_back(mk(1,  1, 0, 0, 25,  3, 1,      pf(0,25,0),                     3, 1));
      vecs.push_back(mk(1,  1, 0, 0, 26,  3, 1,      pf(0,25,0),                     3, 1));
      vecs.push_back(mk(10, 1, 0, 0,  5,  3, 1,      pf(0,25,0),                     3, 1));
      vecs.push_back(mk(0,  0, 0, 0,  0,  3, 1,      pf(0,25,0),                     3, 0));
      vecs.push_back(mk(2,  1, 0, 0,  4,  3, 1,      pf(0,25,0) | pf(2,0,4),         3, 0));
      vecs.push_back(mk(2,  1, 0, 0,  4,  3, 1,      pf(0,25,0) | pf(2,0,4),         3, 1));
      vecs.push_back(mk(2,  1, 0, 0,  7,  3, 10'h5,  pf(0,25,0) | pf(2,7,4),         3, 0));
      vecs.push_back(mk(0,  0, 0, 0,  0,  7, 10'h5,  pf(0,25,0) | pf(2,7,4),         4, 0));
      vecs.push_back(mk(0,  1, 0, 0, 25,  0, 10'h4,  pf(0,0,25) | pf(2,7,4),        25, 0));
      vecs.push_back(mk(0,  0, 0, 0,  0,  0, 10'h4,  pf(0,0,25) | pf(2,7,4),         0, 0));
      vecs.push_back(mk(3,  1, 0, 0,  9,  0, 10'h4,  pf(0,0,25) | pf(2,7,4) | pf(3,0,9), 0, 0));
      vecs.push_back(mk(3,  1, 0, 0, 25,  0, 10'h4,  pf(0,0,25) | pf(2,7,4) | pf(3,0,9), 0, 1));
      vecs.push_back(mk(2,  1, 1, 0, 11,  0, 0,      pf(0,0,25) | pf(3,0,9),         0, 0));
      vecs.push_back(mk(12, 0, 1, 0,  0, 25, 0,      pf(0,0,25) | pf(3,0,9),        25, 0));
      vecs.push_back(mk(1,  1, 1, 1,  5,  0, 0,      '0,                             0, 0));
      vecs.push_back(mk(1,  1, 0, 0,  5,  0, 0,      pf(1,0,5),                      0, 0));

      tick();
      chk_all("reset", '0, '0, '0, 1'b0);
      rst = 1'b0;
      tick();
      chk_all("post_reset", '0, '0, '0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(int'(vecs[i].sel), vecs[i].ld, vecs[i].clr, vecs[i].clr_all,
               int'(vecs[i].let_v), int'(vecs[i].swap_in));
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].act, vecs[i].f, vecs[i].swap_out, vecs[i].err);
      end

      // LD held across three edges counts as three loads into pair 4.
      drive(4, 1, 0, 0, 6, 0);
      tick();
      chk_all("hold1", '0, pf(1,0,5) | pf(4,0,6), '0, 1'b0);
      bus.LET = 5'd8;
      tick();
      chk_all("hold2", 10'h10, pf(1,0,5) | pf(4,8,6), '0, 1'b0);
      bus.LET = 5'd10;
      tick();
      chk_all("hold3", '0, pf(1,0,5) | pf(4,0,10), '0, 1'b0);

      // Build a full pair, a half pair and a pending ERR, then reset between edges.
      drive(1, 1, 0, 0, 2, 0);
      tick();
      drive(3, 1, 0, 0, 3, 0);
      tick();
      drive(3, 1, 0, 0, 2, 5);
      tick();
      chk_all("pre_rst", 10'h2, pf(1,2,5) | pf(3,0,3) | pf(4,0,10), 5'd2, 1'b1);
      drive(3, 1, 0, 0, 3, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", '0, '0, '0, 1'b0);
      tick();
      tick();
      chk_all("rst_hold", '0, '0, '0, 1'b0);
      rst = 1'b0;
      #1;
      chk_all("rst_release", '0, '0, '0, 1'b0);
      tick();
      chk_all("first_edge", '0, pf(3,0,3), '0, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk_all("idle_end", '0, pf(3,0,3), '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/plug_bank.md
PLUG_BANK -- requirements
Module: plug_bank

Interface
REQ-001 SHALL have parameter NUM_PAIRS, default 10; number of plugboard pairs, range 1..13.
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_PAIRS) (minimum 1); pair-select width.
REQ-003 SHALL have port CLK  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port SEL  input  SEL_W  index of the pair targeted by LD/CLR.
REQ-006 SHALL have port LD  input  1  one-cycle strobe; load LET into pair SEL.
REQ-007 SHALL have port LET  input  5  letter code, 0=A..25=Z.
REQ-008 SHALL have port CLR  input  1  one-cycle strobe; clear pair SEL.
REQ-009 SHALL have port CLR_ALL  input  1  one-cycle strobe; clear all pairs.
REQ-010 SHALL have port SWAP_IN  input  5  letter to pass through the plugboard.
REQ-011 SHALL have port ACT  output  NUM_PAIRS  bit i high when pair i is FULL.
REQ-012 SHALL have port F  output  10*NUM_PAIRS  pair i at F[10i+9:10i]: {second letter, first letter}.
REQ-013 SHALL have port SWAP_OUT  output  5  plugboard-mapped SWAP_IN, registered.
REQ-014 SHALL have port ERR  output  1  one-cycle pulse on a rejected LD.

Function
REQ-015 Each pair SHALL hold an FSM with states EMPTY, HALF, FULL, plus 5-bit letter registers A and B.
REQ-016 Accepted LD in EMPTY: A<=LET, go to HALF; in HALF: B<=LET, go to FULL; in FULL: A<=LET, B<=0, go to HALF.
REQ-017 LD SHALL be rejected (no state change, ERR=1 next cycle) if LET>25, if SEL>=NUM_PAIRS, or if LET equals any held letter (A of HALF/FULL pairs, B of FULL pairs) of any pair, including the target pair's own A, except letters the LD itself discards (target pair in FULL).
REQ-018 CLR SHALL return pair SEL to EMPTY with A=B=0; CLR with SEL>=NUM_PAIRS SHALL be ignored without ERR.
REQ-019 CLR_ALL SHALL return every pair to EMPTY with A=B=0.
REQ-020 Priority SHALL be CLR_ALL > CLR > LD; a lower-priority strobe in the same cycle is dropped without ERR.
REQ-021 ACT and F SHALL be driven directly from pair registers; they change in the cycle after the accepted strobe.
REQ-022 F for a pair not FULL SHALL show current registers (A valid in HALF, zeros in EMPTY).
REQ-023 SWAP_OUT SHALL be registered with 1-cycle latency: B if SWAP_IN equals A of a FULL pair, A if it equals B of a FULL pair, else SWAP_IN.
REQ-024 Because REQ-017 guarantees uniqueness, at most one FULL pair SHALL match SWAP_IN; the swap logic is a parallel OR of per-pair matches.
REQ-025 ERR SHALL be a registered pulse, high exactly one cycle after each rejected LD, low otherwise.
REQ-026 LD held high for k cycles SHALL be treated as k strobes.

Reset
REQ-027 RST high SHALL asynchronously force all pairs to EMPTY, A=B=0, ACT=0, F=0, SWAP_OUT=0, ERR=0.
REQ-028 RST asserted mid-load (pair in HALF) SHALL discard the partial pair; strobes during RST are ignored.
REQ-029 After RST deasserts, the first rising edge SHALL accept strobes normally.

Structure
REQ-030 Package plug_pkg SHALL hold the pair state enum (EMPTY, HALF, FULL), constant ALPHA_LEN=26, and the 5-bit letter typedef.
REQ-031 Sub-module plug_pair_fsm SHALL implement one pair (FSM, A/B registers, held-letter outputs); plug_bank instantiates NUM_PAIRS copies via generate, plus select decode, conflict check, swap and ERR logic.
REQ-032 The conflict check SHALL be combinational across all pairs in the LD cycle; no multi-cycle search.

Verification
REQ-033 Reset, LD SEL=0 LET=0, then LD SEL=0 LET=25 -> ACT[0]=1, F[9:0]={25,0}; SWAP_IN=0 -> SWAP_OUT=25 next cycle; SWAP_IN=3 -> SWAP_OUT=3.
REQ-034 Pair 0 = {A,Z}; LD SEL=1 LET=25 -> ERR pulse one cycle, pair 1 stays EMPTY; LD SEL=1 LET=26 -> ERR pulse.
REQ-035 Pair 2 in HALF with A=4; LD SEL=2 LET=4 -> ERR; LD SEL=2 LET=7 -> ACT[2]=1, F[29:20]={7,4}.
REQ-036 Pair 0 FULL {0,25}; LD SEL=0 LET=25 -> accepted, pair 0 HALF A=25, ACT[0]=0, SWAP_IN=0 -> SWAP_OUT=0.
REQ-037 CLR_ALL, CLR SEL=1 and LD SEL=1 in the same cycle -> all pairs EMPTY, ERR stays 0.
REQ-038 Pair 3 HALF, assert RST asynchronously between edges -> ACT, F, SWAP_OUT, ERR zero immediately, pair 3 EMPTY after release.
